pipe_ctrl: RTL
==============

// Module: pipe_ctrl
// PURPOSE
//   Pipeline sequencer for the 5-stage core. Drives the per-stage stall vector and flush used by
//   if_id, id_ex, ex_mem and mem_wb. Resolves ID load-use stalls, holds the pipeline while EX runs
//   a multi-cycle op (div, madd/msub), and aborts all of it on an exception flush.
//   Keeps a saturating count of stalled cycles for debug.
// PARAMETERS
//   CNT_W     5    width of multi-cycle length/counter (max op length 2^CNT_W-1 cycles)
//   PERF_W    32   width of stall-cycle performance counter
// PORTS
//   clk          in   1        clock, rising edge
//   rst          in   1        synchronous reset, active-high (RstEnable)
//   id_stallreq  in   1        ID load-use hazard, level, valid each cycle
//   ex_mc_req    in   1        EX starts a multi-cycle op this cycle (1-cycle pulse)
//   ex_mc_len    in   CNT_W    total EX cycles of that op, sampled with ex_mc_req
//   flush_req    in   1        exception/eret flush request (1-cycle pulse)
//   stall        out  6        [0]pc [1]if_id [2]id_ex [3]ex_mem [4]mem_wb [5]=0 always
//   flush        out  1        registered: clear all pipeline regs, 1 cycle
//   mc_busy      out  1        multi-cycle op in progress (state MC_RUN)
//   mc_done      out  1        registered 1-cycle pulse: EX result valid, pipeline released
//   mc_abort     out  1        registered 1-cycle pulse: running op killed by flush
//   stall_cnt    out  PERF_W   stalled-cycle count (cycles with stall[0]=1), saturates at all-ones
// BEHAVIOUR
//   Reset (rst=1 at posedge): state=IDLE, cnt=0, flush=0, mc_done=0, mc_abort=0, stall_cnt=0.
//     While rst=1, stall=6'b000000. Reset mid-operation drops the op; no done or abort pulse.
//   States: IDLE, MC_RUN, FLUSH. cnt is the CNT_W down-counter of remaining EX cycles.
//   Stall vector, combinational from state and inputs, in priority order:
//     flush_req=1 or state=FLUSH            -> 6'b000000
//     state=MC_RUN                          -> 6'b001111 (pc..id_ex held, ex_mem gets bubble)
//     IDLE, ex_mc_req=1, ex_mc_len>=2       -> 6'b001111 (stall starts in the request cycle)
//     IDLE, id_stallreq=1                   -> 6'b000111 (id_ex gets bubble)
//     otherwise                             -> 6'b000000
//   Transitions at posedge, flush_req always wins:
//     any state, flush_req=1  -> FLUSH; flush<=1; mc_abort<=1 if state was MC_RUN; cnt<=0
//     FLUSH                   -> IDLE; flush<=0. A flush_req in this cycle re-enters FLUSH.
//     IDLE, ex_mc_req=1, len>=2 -> MC_RUN; cnt<=len-1
//     IDLE, ex_mc_req, len<=1 -> stay IDLE; treated as single-cycle, no stall, no mc_done
//     MC_RUN, cnt>1           -> cnt<=cnt-1
//     MC_RUN, cnt==1          -> IDLE; mc_done<=1, so the release cycle has stall=0
//     MC_RUN ignores ex_mc_req and id_stallreq (both fully masked).
//   Latency: op of length L holds stall[3:0] for exactly L cycles, request cycle included.
//     mc_done is high in cycle L+1. The stall drops in that same cycle.
//   mc_busy = (state==MC_RUN). flush, mc_done and mc_abort are 1-cycle pulses, default 0.
//   stall_cnt increments by 1 each cycle stall[0]=1. Holds at {PERF_W{1'b1}}, no wrap.
// TESTING
//   1 rst high 3 cycles, then low -> stall=0, flush=0, stall_cnt=0, state IDLE
//   2 id_stallreq=1 for 2 cycles -> stall=6'b000111 both cycles, then 0; stall_cnt=2
//   3 ex_mc_req with len=4 at T0 -> stall=6'b001111 in T0..T3, mc_busy in T1..T3, mc_done=1 and stall=0 at T4
//   4 ex_mc_req len=1, and len=0 -> no stall, no mc_busy, no mc_done
//   5 len=8 op, flush_req at 3rd stalled cycle -> stall=0 in that cycle; next cycle flush=1, mc_abort=1, no mc_done
//   6 id_stallreq + ex_mc_req len=3 same cycle -> 6'b001111 for 3 cycles; back-to-back flush_req in FLUSH -> flush held 2 cycles

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Sequencer bus: hazard/multi-cycle/flush requests in, stall vector and status out.
// master = pipeline side issuing requests; slave = the sequencer.
interface pipe_ctrl_if #(
    parameter int CNT_W  = 5,
    parameter int PERF_W = 32
);
    logic              id_stallreq;
    logic              ex_mc_req;
    logic [CNT_W-1:0]  ex_mc_len;
    logic              flush_req;
    logic [5:0]        stall;
    logic              flush;
    logic              mc_busy;
    logic              mc_done;
    logic              mc_abort;
    logic [PERF_W-1:0] stall_cnt;

    modport master (
        output id_stallreq, ex_mc_req, ex_mc_len, flush_req,
        input  stall, flush, mc_busy, mc_done, mc_abort, stall_cnt
    );

    modport slave (
        input  id_stallreq, ex_mc_req, ex_mc_len, flush_req,
        output stall, flush, mc_busy, mc_done, mc_abort, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall vector is combinational (0 cycles); flush/mc_done/mc_abort register 1 cycle later.
// No backpressure: every request is consumed in the cycle it appears; MC_RUN masks new requests, flush pre-empts all.
module pipe_ctrl #(
    parameter int CNT_W  = 5,
    parameter int PERF_W = 32
) (
    input  logic   clk,
    input  logic   rst,
    pipe_ctrl_if.slave pc
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MC_RUN = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              flush_q, flush_nxt;
    logic              done_q, done_nxt;
    logic              abort_q, abort_nxt;
    logic [PERF_W-1:0] perf_q;
    logic [5:0]        stall_c;
    logic              mc_start;

    // Ops of length 0 or 1 finish inside the normal EX cycle and never enter MC_RUN.
    assign mc_start = pc.ex_mc_req && (pc.ex_mc_len >= CNT_W'(2));

    always_comb begin
        stall_c = 6'b000000;
        if (rst) begin
            stall_c = 6'b000000;
        end else if (pc.flush_req || state == FLUSH) begin
            stall_c = 6'b000000;
        end else if (state == MC_RUN) begin
            stall_c = 6'b001111;
        end else if (mc_start) begin
            stall_c = 6'b001111;
        end else if (pc.id_stallreq) begin
            stall_c = 6'b000111;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        flush_nxt = 1'b0;
        done_nxt  = 1'b0;
        abort_nxt = 1'b0;
        if (pc.flush_req) begin
            state_nxt = FLUSH;
            flush_nxt = 1'b1;
            abort_nxt = (state == MC_RUN);
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mc_start) begin
                        state_nxt = MC_RUN;
                        cnt_nxt   = pc.ex_mc_len - CNT_W'(1);
                    end
                end
                MC_RUN: begin
                    if (cnt > CNT_W'(1)) begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        done_nxt  = 1'b1;
                    end
                end
                FLUSH: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            flush_q <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            perf_q  <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            flush_q <= flush_nxt;
            done_q  <= done_nxt;
            abort_q <= abort_nxt;
            if (stall_c[0] && (perf_q != {PERF_W{1'b1}})) begin
                perf_q <= perf_q + PERF_W'(1);
            end
        end
    end

    assign pc.stall     = stall_c;
    assign pc.flush     = flush_q;
    assign pc.mc_busy   = (state == MC_RUN);
    assign pc.mc_done   = done_q;
    assign pc.mc_abort  = abort_q;
    assign pc.stall_cnt = perf_q;
endmodule
